// File: rtl/kintex_dpr_responder_if.sv
// Bundle of the DPR request, bitstream ROM and ICAP streaming signals.
// The responder connects through the slave modport; the healer, ROM and
// ICAP side (or a bench standing in for them) uses the master modport.
interface kintex_dpr_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
) ();
    logic              dpr_start;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] icap_data;
    logic              icap_valid;
    logic              icap_ready;
    logic              dpr_busy;
    logic              dpr_done;
    logic              dpr_error;
    logic [1:0]        err_code;

    // Healer / ROM / ICAP side of the link
    modport master (
        output dpr_start,
        output mem_rdata,
        output icap_ready,
        input  mem_rd_en,
        input  mem_addr,
        input  icap_data,
        input  icap_valid,
        input  dpr_busy,
        input  dpr_done,
        input  dpr_error,
        input  err_code
    );

    // Responder side of the link
    modport slave (
        input  dpr_start,
        input  mem_rdata,
        input  icap_ready,
        output mem_rd_en,
        output mem_addr,
        output icap_data,
        output icap_valid,
        output dpr_busy,
        output dpr_done,
        output dpr_error,
        output err_code
    );
endinterface

// File: rtl/kintex_dpr_responder.sv
// DPR responder: on a start request, reads a partial bitstream word by word
// from the ROM and streams it to the ICAP over valid/ready. Word 0 must be the
// sync word, consecutive ICAP stalls are bounded, and the whole transfer is
// bounded by a global cycle budget. Completion and a 2-bit error code are
// reported back to the healer.
module kintex_dpr_responder #(
    parameter int                 DATA_W          = 32,
    parameter int                 ADDR_W          = 16,
    parameter int                 BITSTREAM_WORDS = 4096,
    parameter logic [DATA_W-1:0]  SYNC_WORD       = 32'hAA995566,
    parameter int                 STALL_LIMIT     = 1024,
    parameter int                 TIMEOUT_CYCLES  = 12500000
) (
    input  logic                    clk_500mhz,
    input  logic                    rst,
    kintex_dpr_responder_if.slave   bus
);

    localparam logic [ADDR_W-1:0]  LAST_IDX  = ADDR_W'(BITSTREAM_WORDS - 1);
    localparam int                 STALL_W   = $clog2(STALL_LIMIT + 1);
    localparam int                 TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);
    localparam logic [TMO_W-1:0]   TMO_MAX   = TMO_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_STALL   = 2'b10;
    localparam logic [1:0] ERR_SYNC    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SEND  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [ADDR_W-1:0]  idx_r;
    logic [STALL_W-1:0] stall_cnt_r;
    logic [TMO_W-1:0]   tmo_cnt_r;
    logic [DATA_W-1:0]  icap_data_r;
    logic [1:0]         err_code_r;
    logic [1:0]         err_code_s;

    logic               start_acc_s;
    logic               xfer_s;
    logic               last_s;
    logic               tmo_hit_s;
    logic               stall_hit_s;
    logic               sync_bad_s;
    logic               rd_en_s;
    logic [ADDR_W-1:0]  addr_s;

    // A start is only honoured from IDLE; anywhere else it is dropped.
    assign start_acc_s = (state_r == ST_IDLE) && bus.dpr_start;

    // A word moves to the ICAP only while SEND presents it and ICAP is ready.
    assign xfer_s      = (state_r == ST_SEND) && bus.icap_ready;
    assign last_s      = (idx_r == LAST_IDX);

    // The global budget expires in the cycle that completes TIMEOUT_CYCLES
    // non-IDLE cycles; DONE is already on its way out, so it is exempt.
    assign tmo_hit_s   = ((state_r == ST_FETCH) || (state_r == ST_LOAD) || (state_r == ST_SEND))
                         && (tmo_cnt_r == (TMO_MAX - TMO_W'(1)));

    // This stalled cycle is the STALL_LIMIT-th consecutive one.
    assign stall_hit_s = (state_r == ST_SEND) && !bus.icap_ready
                         && (stall_cnt_r == (STALL_MAX - STALL_W'(1)));

    // Word 0 arriving from the ROM must carry the sync word.
    assign sync_bad_s  = (state_r == ST_LOAD) && (idx_r == '0)
                         && (bus.mem_rdata != SYNC_WORD);

    // Next-state and error-code selection, including the same-cycle priorities.
    always_comb begin
        state_s    = state_r;
        err_code_s = err_code_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.dpr_start) begin
                    state_s    = ST_FETCH;
                    err_code_s = ERR_OK;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (tmo_hit_s) begin
                    state_s    = ST_DONE;
                    err_code_s = ERR_TIMEOUT;
                end else begin
                    state_s    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Timeout outranks a coincident sync mismatch.
                if (tmo_hit_s) begin
                    state_s    = ST_DONE;
                    err_code_s = ERR_TIMEOUT;
                end else if (sync_bad_s) begin
                    state_s    = ST_DONE;
                    err_code_s = ERR_SYNC;
                end else begin
                    state_s    = ST_SEND;
                end
            end
            ST_SEND: begin
                // Delivering the final word wins over any coincident error;
                // after that, timeout outranks stall.
                if (xfer_s && last_s) begin
                    state_s    = ST_DONE;
                end else if (tmo_hit_s) begin
                    state_s    = ST_DONE;
                    err_code_s = ERR_TIMEOUT;
                end else if (xfer_s) begin
                    state_s    = ST_LOAD;
                end else if (stall_hit_s) begin
                    state_s    = ST_DONE;
                    err_code_s = ERR_STALL;
                end else begin
                    state_s    = ST_SEND;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // ROM read strobe: once in FETCH for word 0, then overlapped with each
    // non-final transfer so the next word lands in the following LOAD cycle.
    always_comb begin
        rd_en_s = 1'b0;
        addr_s  = idx_r;
        if (state_r == ST_FETCH) begin
            rd_en_s = 1'b1;
            addr_s  = idx_r;
        end else if ((state_r == ST_SEND) && (state_s == ST_LOAD)) begin
            rd_en_s = 1'b1;
            addr_s  = idx_r + ADDR_W'(1);
        end else begin
            rd_en_s = 1'b0;
            addr_s  = idx_r;
        end
    end

    // FSM state and latched error code.
    always_ff @(posedge clk_500mhz) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            err_code_r <= ERR_OK;
        end else begin
            state_r    <= state_s;
            err_code_r <= err_code_s;
        end
    end

    // Word index: cleared on acceptance, advanced alongside each read-ahead.
    always_ff @(posedge clk_500mhz) begin
        if (rst) begin
            idx_r <= '0;
        end else if (start_acc_s) begin
            idx_r <= '0;
        end else if ((state_r == ST_SEND) && (state_s == ST_LOAD)) begin
            idx_r <= idx_r + ADDR_W'(1);
        end else begin
            idx_r <= idx_r;
        end
    end

    // Consecutive-stall counter; any transfer restarts the count.
    always_ff @(posedge clk_500mhz) begin
        if (rst) begin
            stall_cnt_r <= '0;
        end else if (start_acc_s) begin
            stall_cnt_r <= '0;
        end else if (xfer_s) begin
            stall_cnt_r <= '0;
        end else if (state_r == ST_SEND) begin
            stall_cnt_r <= stall_cnt_r + STALL_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Global budget counter, running from acceptance until DONE is reached.
    always_ff @(posedge clk_500mhz) begin
        if (rst) begin
            tmo_cnt_r <= '0;
        end else if (start_acc_s) begin
            tmo_cnt_r <= '0;
        end else if ((state_r == ST_FETCH) || (state_r == ST_LOAD) || (state_r == ST_SEND)) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    // ICAP data holding register: loaded in LOAD, held stable through SEND.
    always_ff @(posedge clk_500mhz) begin
        if (rst) begin
            icap_data_r <= '0;
        end else if (state_r == ST_LOAD) begin
            icap_data_r <= bus.mem_rdata;
        end else begin
            icap_data_r <= icap_data_r;
        end
    end

    assign bus.mem_rd_en  = rd_en_s;
    assign bus.mem_addr   = addr_s;
    assign bus.icap_data  = icap_data_r;
    assign bus.icap_valid = (state_r == ST_SEND);
    assign bus.dpr_busy   = (state_r != ST_IDLE);
    assign bus.dpr_done   = (state_r == ST_DONE);
    assign bus.dpr_error  = (state_r == ST_DONE) && (err_code_r != ERR_OK);
    assign bus.err_code   = err_code_r;

endmodule

// File: tb/tb_kintex_dpr_responder.sv
// Scoreboard bench for kintex_dpr_responder. Three instances cover the small
// configurations needed: A (N=4, stall limit 8, generous budget), B (N=16,
// budget 20) and C (N=4, budget 9, last word coincides with the budget).
// Stimulus pushes expected ICAP transfers and done reports (with the edge on
// which each must happen) into a queue; monitors pop and compare them.
module tb_kintex_dpr_responder;

    logic clk;
    logic rst;
    int   cyc;
    int   errors;
    int   checks;

    localparam int K_XFER = 0;
    localparam int K_DONE = 1;

    typedef struct {
        int          inst;
        int          kind;
        int          edge_n;
        logic [31:0] data;
    } evt_t;

    evt_t exp_q[$];

    logic [31:0] rom_a [4];
    logic [31:0] rom_b [16];
    logic [31:0] rom_c [4];

    kintex_dpr_responder_if #(.DATA_W(32), .ADDR_W(16)) bus_a ();
    kintex_dpr_responder_if #(.DATA_W(32), .ADDR_W(16)) bus_b ();
    kintex_dpr_responder_if #(.DATA_W(32), .ADDR_W(16)) bus_c ();

    kintex_dpr_responder #(.BITSTREAM_WORDS(4), .STALL_LIMIT(8), .TIMEOUT_CYCLES(1000))
        dut_a (.clk_500mhz(clk), .rst(rst), .bus(bus_a));
    kintex_dpr_responder #(.BITSTREAM_WORDS(16), .STALL_LIMIT(1024), .TIMEOUT_CYCLES(20))
        dut_b (.clk_500mhz(clk), .rst(rst), .bus(bus_b));
    kintex_dpr_responder #(.BITSTREAM_WORDS(4), .STALL_LIMIT(8), .TIMEOUT_CYCLES(9))
        dut_c (.clk_500mhz(clk), .rst(rst), .bus(bus_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ROM models: data valid one cycle after the read strobe
    always @(posedge clk) if (bus_a.mem_rd_en) bus_a.mem_rdata <= rom_a[bus_a.mem_addr[1:0]];
    always @(posedge clk) if (bus_b.mem_rd_en) bus_b.mem_rdata <= rom_b[bus_b.mem_addr[3:0]];
    always @(posedge clk) if (bus_c.mem_rd_en) bus_c.mem_rdata <= rom_c[bus_c.mem_addr[1:0]];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic void push(input int inst, input int kind, input int edge_n, input logic [31:0] data);
        evt_t e;
        e.inst = inst; e.kind = kind; e.edge_n = edge_n; e.data = data;
        exp_q.push_back(e);
    endfunction

    function automatic void observe(input int inst, input int kind, input logic [31:0] data);
        evt_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_evt: inst %0d kind %0d data %0h at edge %0d, required none",
                     inst, kind, data, cyc + 1);
        end else begin
            e = exp_q.pop_front();
            if (e.inst != inst || e.kind != kind || e.edge_n != cyc + 1 || e.data !== data) begin
                errors++;
                $display("FAIL evt: got inst %0d kind %0d edge %0d data %0h, required inst %0d kind %0d edge %0d data %0h",
                         inst, kind, cyc + 1, data, e.inst, e.kind, e.edge_n, e.data);
            end
        end
    endfunction

    function automatic void mon(input int inst, input logic v, input logic r, input logic [31:0] d,
                                input logic done, input logic er, input logic [1:0] code,
                                input logic rd, input logic [15:0] addr, input int n_words);
        if (v && r) observe(inst, K_XFER, d);
        if (done) begin
            observe(inst, K_DONE, {29'd0, er, code});
            chk("valid_in_done", {63'd0, v}, 64'd0);
        end
        if (rd) chk("addr_range", {63'd0, (int'(addr) <= n_words - 1)}, 64'd1);
    endfunction

    // Monitors sample just after the falling edge, after stimulus has settled
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            mon(0, bus_a.icap_valid, bus_a.icap_ready, bus_a.icap_data, bus_a.dpr_done,
                bus_a.dpr_error, bus_a.err_code, bus_a.mem_rd_en, bus_a.mem_addr, 4);
            mon(1, bus_b.icap_valid, bus_b.icap_ready, bus_b.icap_data, bus_b.dpr_done,
                bus_b.dpr_error, bus_b.err_code, bus_b.mem_rd_en, bus_b.mem_addr, 16);
            mon(2, bus_c.icap_valid, bus_c.icap_ready, bus_c.icap_data, bus_c.dpr_done,
                bus_c.dpr_error, bus_c.err_code, bus_c.mem_rd_en, bus_c.mem_addr, 4);
        end
    end

    function automatic logic busy_of(input int inst);
        case (inst)
            0:       return bus_a.dpr_busy;
            1:       return bus_b.dpr_busy;
            default: return bus_c.dpr_busy;
        endcase
    endfunction

    function automatic logic [63:0] outs_of(input int inst);
        case (inst)
            0: return {9'd0, bus_a.dpr_busy, bus_a.icap_valid, bus_a.dpr_done, bus_a.dpr_error,
                       bus_a.err_code, bus_a.mem_rd_en, bus_a.mem_addr, bus_a.icap_data};
            1: return {9'd0, bus_b.dpr_busy, bus_b.icap_valid, bus_b.dpr_done, bus_b.dpr_error,
                       bus_b.err_code, bus_b.mem_rd_en, bus_b.mem_addr, bus_b.icap_data};
            default: return {9'd0, bus_c.dpr_busy, bus_c.icap_valid, bus_c.dpr_done, bus_c.dpr_error,
                       bus_c.err_code, bus_c.mem_rd_en, bus_c.mem_addr, bus_c.icap_data};
        endcase
    endfunction

    function automatic logic [1:0] code_of(input int inst);
        case (inst)
            0:       return bus_a.err_code;
            1:       return bus_b.err_code;
            default: return bus_c.err_code;
        endcase
    endfunction

    task automatic set_start(input int inst, input logic val);
        case (inst)
            0:       bus_a.dpr_start = val;
            1:       bus_b.dpr_start = val;
            default: bus_c.dpr_start = val;
        endcase
    endtask

    // Called at a falling edge; returns T, the rising edge sampling the start
    task automatic start(input int inst, output int t);
        set_start(inst, 1'b1);
        t = cyc + 1;
        @(negedge clk);
        set_start(inst, 1'b0);
        chk("busy_rise", {63'd0, busy_of(inst)}, 64'd1);
    endtask

    // Advance to the falling edge just before rising edge e
    task automatic wait_edge(input int e);
        int n;
        n = 0;
        while (cyc + 1 < e && n < 1000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_idle(input int inst, input int fall_edge, input int budget);
        int n;
        n = 0;
        while (busy_of(inst) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy_of(inst)) begin
            checks++;
            errors++;
            $display("FAIL wait_budget: inst %0d still busy after %0d cycles, required idle", inst, budget);
        end else begin
            chk("busy_fall_edge", 64'(cyc + 1), 64'(fall_edge));
        end
    endtask

    task automatic push_nominal_a(input int t);
        for (int k = 0; k < 4; k++) push(0, K_XFER, t + 3 + 2 * k, rom_a[k]);
        push(0, K_DONE, t + 10, 32'd0);
    endtask

    initial begin
        int t;
        errors = 0;
        checks = 0;
        cyc    = 0;
        rst    = 1'b1;
        bus_a.dpr_start = 1'b0; bus_b.dpr_start = 1'b0; bus_c.dpr_start = 1'b0;
        bus_a.icap_ready = 1'b1; bus_b.icap_ready = 1'b1; bus_c.icap_ready = 1'b1;
        rom_a[0] = 32'hAA995566; rom_a[1] = 32'd1; rom_a[2] = 32'd2; rom_a[3] = 32'd3;
        rom_c[0] = 32'hAA995566; rom_c[1] = 32'd1; rom_c[2] = 32'd2; rom_c[3] = 32'd3;
        rom_b[0] = 32'hAA995566;
        for (int k = 1; k < 16; k++) rom_b[k] = 32'(k);

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) chk("reset_outs", outs_of(i), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Nominal transfer: words at T+3/5/7/9, done at T+10, idle at T+11
        start(0, t);
        push_nominal_a(t);
        wait_idle(0, t + 11, 40);
        chk("nominal_err_code", {62'd0, code_of(0)}, 64'd0);

        // Sync mismatch, started back-to-back on the first IDLE cycle
        rom_a[0] = 32'hDEADBEEF;
        start(0, t);
        push(0, K_DONE, t + 3, 32'd7);
        wait_idle(0, t + 4, 20);
        chk("sync_err_code", {62'd0, code_of(0)}, 64'd3);
        rom_a[0] = 32'hAA995566;
        @(negedge clk);

        // Stall: ready drops after word 0; eight stalled cycles T+5..T+12
        start(0, t);
        push(0, K_XFER, t + 3, 32'hAA995566);
        push(0, K_DONE, t + 13, 32'd6);
        wait_edge(t + 4);
        bus_a.icap_ready = 1'b0;
        for (int e = t + 5; e <= t + 12; e++) begin
            wait_edge(e);
            chk("stall_valid", {63'd0, bus_a.icap_valid}, 64'd1);
            chk("stall_data", {32'd0, bus_a.icap_data}, 64'd1);
        end
        wait_idle(0, t + 14, 50);
        chk("stall_err_code", {62'd0, code_of(0)}, 64'd2);
        bus_a.icap_ready = 1'b1;
        @(negedge clk);

        // Second start during SEND is ignored
        start(0, t);
        push_nominal_a(t);
        wait_edge(t + 7);
        bus_a.dpr_start = 1'b1;
        @(negedge clk);
        bus_a.dpr_start = 1'b0;
        wait_idle(0, t + 11, 40);
        repeat (4) @(negedge clk);
        chk("busy_start_err_code", {62'd0, code_of(0)}, 64'd0);

        // Reset while word 2 is being loaded
        start(0, t);
        push(0, K_XFER, t + 3, 32'hAA995566);
        push(0, K_XFER, t + 5, 32'd1);
        wait_edge(t + 6);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_outs", outs_of(0), 64'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_no_done", 64'(exp_q.size()), 64'd0);

        // Fresh start after reset
        start(0, t);
        push_nominal_a(t);
        wait_idle(0, t + 11, 40);
        chk("post_rst_err_code", {62'd0, code_of(0)}, 64'd0);

        // Timeout: budget 20 expires in LOAD at T+20 after word 8 at T+19
        start(1, t);
        for (int k = 0; k <= 8; k++) push(1, K_XFER, t + 3 + 2 * k, rom_b[k]);
        push(1, K_DONE, t + 21, 32'd5);
        wait_idle(1, t + 22, 60);
        chk("timeout_err_code", {62'd0, code_of(1)}, 64'd1);

        // Tie: last word at T+9 on the same edge the budget of 9 expires
        start(2, t);
        for (int k = 0; k < 4; k++) push(2, K_XFER, t + 3 + 2 * k, rom_c[k]);
        push(2, K_DONE, t + 10, 32'd0);
        wait_idle(2, t + 11, 40);
        chk("tie_err_code", {62'd0, code_of(2)}, 64'd0);

        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t, required finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/kintex_dpr_responder.md
# kintex_dpr_responder

Responder end of the healer's DPR request. On a `dpr_start` pulse it loads the partial bitstream from the bitstream ROM and streams it word by word to the configuration port (ICAP) over a valid/ready handshake. It reports completion or a coded error back to the healer, guarding the transfer with a sync-word check, a per-word stall limit and a 25 ms global timeout.

## Interface
- `DATA_W`, 32, bitstream word width
- `ADDR_W`, 16, ROM address width
- `BITSTREAM_WORDS`, 4096, words per partial bitstream (≥1, ≤2^ADDR_W)
- `SYNC_WORD`, 32'hAA995566, required value of word 0
- `STALL_LIMIT`, 1024, max consecutive cycles with `icap_valid` high and `icap_ready` low
- `TIMEOUT_CYCLES`, 12500000, global budget from start acceptance (25 ms at 500 MHz)

Ports:
- `clk_500mhz`  in  1  sole clock, all logic on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `dpr_start`  in  1  request from the healer, sampled every cycle
- `mem_rd_en`  out  1  ROM read strobe
- `mem_addr`  out  ADDR_W  ROM word address
- `mem_rdata`  in  DATA_W  ROM data, valid exactly 1 cycle after `mem_rd_en`
- `icap_data`  out  DATA_W  configuration word
- `icap_valid`  out  1  `icap_data` valid
- `icap_ready`  in  1  ICAP accepts; a transfer occurs when valid and ready are both high
- `dpr_busy`  out  1  high in every state except IDLE
- `dpr_done`  out  1  1-cycle completion pulse (success or error)
- `dpr_error`  out  1  1-cycle pulse, coincident with `dpr_done` on failure
- `err_code`  out  2  00 ok, 01 timeout, 10 stall, 11 sync mismatch; held until next accepted start

## Operation
- **States:** IDLE, FETCH, LOAD, SEND, DONE.
- **IDLE:** `dpr_start` = 1 → FETCH. Clear the word index, stall counter, timeout counter and `err_code`.
- **FETCH:** `mem_rd_en` = 1 with `mem_addr` = index → LOAD.
- **LOAD:** capture `mem_rdata` into `icap_data`.
  - Index 0 with data ≠ `SYNC_WORD` → `err_code` = 11, go to DONE with the error flagged; the word is not presented.
  - Otherwise → SEND.
- **SEND:** `icap_valid` = 1.
  - On transfer with index = `BITSTREAM_WORDS`−1 → DONE (success).
  - On any other transfer: in the same cycle drive `mem_rd_en` = 1 and `mem_addr` = index+1, increment the index → LOAD.
  - Each valid && !ready cycle increments the stall counter; every transfer clears it.
  - When the stall counter reaches `STALL_LIMIT` → `err_code` = 10, DONE.
- **Timeout:** the counter runs in every non-IDLE state. When it reaches `TIMEOUT_CYCLES` while not yet in DONE → `err_code` = 01, DONE.
- **DONE:** `dpr_done` = 1 for one cycle, `dpr_error` = 1 if any error was flagged → IDLE.
- **Priority within one cycle:** a transfer of the last word beats timeout or stall (success). Timeout beats stall. Sync mismatch and timeout in the same cycle → 01.
- `dpr_start` outside IDLE is ignored; there is no queuing.
- `icap_valid` stays high and `icap_data` stays stable until the transfer completes or an error aborts it. On an abort, `icap_valid` drops in the DONE cycle.
- The index never wraps: `mem_addr` ≤ `BITSTREAM_WORDS`−1 always.

## Timing
- **Reset values:** all outputs 0, state IDLE, all counters 0. Reset mid-transfer aborts immediately. There is no `dpr_done` pulse; `icap_valid` is 0 on the cycle after reset is sampled.
- `dpr_busy`, `icap_valid`, `dpr_done` and `dpr_error` decode from registered state only. `mem_rd_en` and `mem_addr` also depend on the same-cycle handshake.
- **Start latency**, with start sampled in IDLE at edge T:
  - FETCH at T+1, where `dpr_busy` rises.
  - LOAD at T+2.
  - SEND at T+3.
- **Throughput:** with `icap_ready` held at 1, word k transfers at T+3+2k. `dpr_done` fires at T+2N+2 for N = `BITSTREAM_WORDS`. `dpr_busy` falls at T+2N+3.
- **Stall error:** `dpr_done` follows the cycle in which the stall count reaches `STALL_LIMIT`.
- **Back-to-back requests:** a new start is accepted on the first IDLE cycle after DONE, i.e. 2 cycles after the `dpr_done` pulse begins.

## Test plan
- **Nominal transfer:** N=4, ROM = {AA995566, 1, 2, 3}, ready = 1, start at T → transfers at T+3/5/7/9 with data 0xAA995566, 1, 2, 3; `dpr_done` at T+10; `dpr_error` 0; `err_code` 00.
- **Sync mismatch:** word 0 = 0xDEADBEEF → no `icap_valid`; `dpr_done` and `dpr_error` at T+3; `err_code` 11.
- **Stall:** `STALL_LIMIT` = 8, ready = 0 from word 1 onward → `dpr_error` with `err_code` 10; `icap_data` stable at word 1 throughout; exactly 1 transfer occurred.
- **Timeout with tie:** `TIMEOUT_CYCLES` = 20, N = 16, ready = 1 → `err_code` 01. A separate run with the last-word transfer in the same cycle the timeout count is reached → success, `err_code` 00.
- **Start while busy / reset mid-run:** a second `dpr_start` during SEND → ignored, only one `dpr_done`. Assert `rst` for 1 cycle at word 2 → all outputs 0 next cycle, no `dpr_done`. A fresh start after reset is accepted normally.
